// File: rtl/run_checker_if.sv
// Checker bus: run control, DUT observation taps, per-slot check table and result status.
// The bench/core wrapper drives the master side; run_checker sits on the slave side.
interface run_checker_if #(
  parameter int NUM_CHECKS = 4
);
  localparam int FW = $clog2(NUM_CHECKS) + 1;

  logic                         start;
  logic [31:0]                  pc_debug;
  logic [31:0]                  regs_debug [0:31];
  logic [NUM_CHECKS-1:0]        chk_en;
  logic [NUM_CHECKS-1:0][4:0]   chk_reg;
  logic [NUM_CHECKS-1:0][31:0]  chk_val;
  logic                         busy;
  logic                         done;
  logic                         pass;
  logic                         timeout;
  logic [NUM_CHECKS-1:0]        fail_mask;
  logic [FW-1:0]                first_fail;
  logic [31:0]                  cycles;

  modport master (
    output start, pc_debug, regs_debug, chk_en, chk_reg, chk_val,
    input  busy, done, pass, timeout, fail_mask, first_fail, cycles
  );

  modport slave (
    input  start, pc_debug, regs_debug, chk_en, chk_reg, chk_val,
    output busy, done, pass, timeout, fail_mask, first_fail, cycles
  );
endinterface

// File: rtl/run_checker.sv
// End-of-program checker: detects halt (stable PC) or timeout, then compares one register slot per cycle.
// Optional simulation trace of mismatches and the final verdict under RUN_CHECKER_TRACE_EN.
module run_checker #(
  parameter int NUM_CHECKS     = 4,
  parameter int HALT_STABLE    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic             clk,
  input logic             reset,
  run_checker_if.slave    bus
);

  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int FW = $clog2(NUM_CHECKS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           cycles_q, cycles_d;
  logic [31:0]           stable_q, stable_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_CHECKS-1:0] fail_q, fail_d;
  logic [FW-1:0]         first_q, first_d;
  logic                  timeout_q, timeout_d;
  logic                  pass_q, pass_d;

  logic pc_same, halt, tmo, last, slot_bad;

  assign pc_same  = (bus.pc_debug == pc_q);
  assign halt     = pc_same && (stable_q == 32'(HALT_STABLE - 1));
  assign tmo      = (cycles_q == 32'(TIMEOUT_CYCLES - 1));
  assign last     = (idx_q == IW'(NUM_CHECKS - 1));
  assign slot_bad = bus.chk_en[idx_q] &&
                    (bus.regs_debug[bus.chk_reg[idx_q]] != bus.chk_val[idx_q]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start)   state_d = S_RUN;
      S_RUN:          if (halt || tmo) state_d = S_CHECK;
      S_CHECK:        if (last)        state_d = S_DONE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == S_RUN) || (state_q == S_CHECK);
    bus.done = (state_q == S_DONE);
  end

  always_comb begin
    pc_d      = pc_q;
    cycles_d  = cycles_q;
    stable_d  = stable_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    first_d   = first_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // Sampling the PC on entry makes a PC that never moves halt after exactly HALT_STABLE cycles.
        if (bus.start) begin
          pc_d      = bus.pc_debug;
          cycles_d  = '0;
          stable_d  = '0;
          idx_d     = '0;
          fail_d    = '0;
          first_d   = '1;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      S_RUN: begin
        cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
        pc_d     = bus.pc_debug;
        stable_d = pc_same ? stable_q + 32'd1 : '0;
        if (!halt && tmo) timeout_d = 1'b1;
        if (halt || tmo)  idx_d     = '0;
      end
      S_CHECK: begin
        if (slot_bad) begin
          fail_d[idx_q] = 1'b1;
          if (fail_q == '0) first_d = FW'(idx_q);
        end
        if (last) pass_d = !timeout_q && (fail_d == '0);
        else      idx_d  = idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      cycles_q  <= '0;
      stable_q  <= '0;
      idx_q     <= '0;
      fail_q    <= '0;
      first_q   <= '1;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      cycles_q  <= cycles_d;
      stable_q  <= stable_d;
      idx_q     <= idx_d;
      fail_q    <= fail_d;
      first_q   <= first_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.pass       = pass_q;
  assign bus.timeout    = timeout_q;
  assign bus.fail_mask  = fail_q;
  assign bus.first_fail = first_q;
  assign bus.cycles     = cycles_q;

`ifdef RUN_CHECKER_TRACE_EN
  always @(posedge clk) begin
    if (reset && state_q == S_CHECK) begin
      if (slot_bad)
        $display("run_checker: slot %0d reg $%0d expected 0x%08h actual 0x%08h",
                 idx_q, bus.chk_reg[idx_q], bus.chk_val[idx_q],
                 bus.regs_debug[bus.chk_reg[idx_q]]);
      if (last)
        $display("run_checker: %s after %0d cycles",
                 timeout_q ? "TIMEOUT" : (pass_d ? "PASS" : "FAIL"), cycles_q);
    end
  end
`else
  // Trace build disabled: no simulation output.
`endif

endmodule
